pixel_fb_writer: RTL

Consumer end of the shape-renderer pixel stream (valid/px/py/pixel_color/done). It clips incoming pixels to the screen and converts 24-bit colour to RGB565. Pixels are queued in a small FIFO, then written into the framebuffer SRAM through a write port with ready backpressure. It also performs a full-screen clear and signals frame completion once the producer's done has been seen and every queued write has retired.

---
 rtl/pixel_fb_writer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pixel_fb_writer.sv
// Framebuffer write side of the shape-renderer pixel stream: clip, RGB888->RGB565,
// queue, and write through a ready-backpressured SRAM port; also runs full-screen clears.
module pixel_fb_writer #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_valid,
  input  logic [7:0]        px,
  input  logic [7:0]        py,
  input  logic [23:0]       pixel_color,
  input  logic              src_done,
  input  logic              clear_req,
  input  logic [23:0]       clear_color,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              clear_done,
  output logic              overflow,
  output logic [15:0]       clip_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PIX_N = FB_W * FB_H;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } fb_wr_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic [15:0] to565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  fb_wr_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [15:0]       clr_data;
  logic              done_pending;

  logic   fifo_empty, fifo_full, xfer, pop, clip, push, fire, clr_last;
  fb_wr_t push_ent;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // Port is a pure function of registers, so addr/data hold while stalled.
  assign mem_we    = (state == CLEAR) || !fifo_empty;
  assign mem_addr  = (state == CLEAR) ? clr_addr : fifo_mem[rd_ptr].addr;
  assign mem_wdata = (state == CLEAR) ? clr_data : fifo_mem[rd_ptr].data;
  assign busy      = (state == CLEAR) || !fifo_empty || done_pending;

  assign xfer = mem_we && mem_ready;
  assign pop  = xfer && (state == IDLE);
  assign clip = pixel_valid && ((int'(px) >= FB_W) || (int'(py) >= FB_H));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = pixel_valid && !clip && (!fifo_full || pop);

  assign push_ent.addr = ADDR_W'(int'(py) * FB_W + int'(px));
  assign push_ent.data = to565(pixel_color);

  assign fire     = done_pending && (state == IDLE) && fifo_empty;
  assign clr_last = (clr_addr == ADDR_W'(PIX_N - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      state        <= IDLE;
      clr_addr     <= '0;
      clr_data     <= '0;
      done_pending <= 1'b0;
      frame_done   <= 1'b0;
      clear_done   <= 1'b0;
      overflow     <= 1'b0;
      clip_cnt     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);

      if (clip && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
      if (pixel_valid && !clip && fifo_full && !pop) overflow <= 1'b1;

      frame_done   <= fire;
      clear_done   <= 1'b0;
      done_pending <= (done_pending && !fire) || src_done;

      case (state)
        IDLE: begin
          if (clear_req && fifo_empty) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_data <= to565(clear_color);
            overflow <= 1'b0;
          end
        end
        CLEAR: begin
          if (xfer) begin
            if (clr_last) begin
              state      <= IDLE;
              clear_done <= 1'b1;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
